// File: rtl/detector_pkg.sv
// rtl/detector_pkg.sv - shared constants, typedefs and state encoding for the edge-detector frame sequencer
//
// Purpose: single source for the pipeline geometry used by the sequencer and
// its tag delay line.
//   PIXEL_HEIGHT : rows per column (width of per-row flag buses)
//   PIPE_LATENCY : cycles from feeding column k to its result at the pipeline tail
//   WARMUP       : leading columns whose averaging windows are not yet full
//   COL_W        : width of column indices and counts
package detector_pkg;

  localparam int PIXEL_HEIGHT = 5;
  localparam int PIPE_LATENCY = 13;
  localparam int WARMUP       = 7;
  localparam int COL_W        = 8;

  typedef logic [PIXEL_HEIGHT-1:0] row_flags_t;
  typedef logic [COL_W-1:0]        col_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FEED   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_REPORT = 2'd3
  } seq_state_t;

endpackage

// File: rtl/valid_tag_delay.sv
// rtl/valid_tag_delay.sv - depth-matched shift register of {valid, column} tags shadowing the pipeline
//
// Purpose: delays a {valid, column index} tag by exactly DEPTH cycles so the
// tag emerges at the tail in the same cycle the pipeline presents that
// column's result. Shifts every cycle; a synchronous flush empties it.
// Ports:
//   clock     : system clock
//   reset_n   : asynchronous active-low clear
//   flush     : synchronous clear of every stage (frame cancelled)
//   in_valid  : tag valid entering stage 0
//   in_col    : column index entering stage 0
//   out_valid : tag valid at the tail (stage DEPTH-1)
//   out_col   : column index at the tail
module valid_tag_delay #(
  parameter int DEPTH = 13,
  parameter int W     = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_col,
  output logic         out_valid,
  output logic [W-1:0] out_col
);

  logic         valid_q [DEPTH];
  logic [W-1:0] col_q   [DEPTH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        col_q[i]   <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        col_q[i]   <= '0;
      end
    end else begin
      valid_q[0] <= in_valid;
      col_q[0]   <= in_col;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        col_q[i]   <= col_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_col   = col_q[DEPTH-1];

endmodule

// File: rtl/edge_frame_sequencer.sv
// rtl/edge_frame_sequencer.sv - sequences one frame of columns through the edge pipeline and builds its report
//
// Purpose: on start, feeds column_count columns (one per cycle) into the edge
// detector pipeline, tracks them with a latency-matched tag delay line,
// accumulates per-row detection flags of post-warm-up columns, then offers a
// frame report over a valid/ready handshake.
// Ports:
//   clock            : system clock, all state on posedge
//   reset_n          : asynchronous active-low reset
//   start            : frame request, sampled only in IDLE
//   abort            : cancel the current frame without a report
//   column_count     : columns in the frame, latched when start is accepted
//   busy             : high whenever not IDLE
//   feed_en          : pipeline advance/load strobe
//   feed_col         : index of the column being fed
//   result_in        : per-row detector flags from the pipeline tail
//   report_valid     : frame report available
//   report_ready     : consumer accepts the report
//   report_hit       : any row detected in any counted column
//   report_mask      : OR of result_in over counted columns
//   report_first_col : earliest counted column with a detection, 0 if none
module edge_frame_sequencer
  import detector_pkg::*;
#(
  parameter int PIXEL_HEIGHT = detector_pkg::PIXEL_HEIGHT,
  parameter int PIPE_LATENCY = detector_pkg::PIPE_LATENCY,
  parameter int WARMUP       = detector_pkg::WARMUP,
  parameter int COL_W        = detector_pkg::COL_W
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [COL_W-1:0]        column_count,
  output logic                    busy,
  output logic                    feed_en,
  output logic [COL_W-1:0]        feed_col,
  input  logic [PIXEL_HEIGHT-1:0] result_in,
  output logic                    report_valid,
  input  logic                    report_ready,
  output logic                    report_hit,
  output logic [PIXEL_HEIGHT-1:0] report_mask,
  output logic [COL_W-1:0]        report_first_col
);

  seq_state_t       state;
  logic [COL_W-1:0] n_q;

  logic             tail_valid;
  logic [COL_W-1:0] tail_col;
  logic             abort_active;
  logic             sample_en;
  logic             last_sample;
  logic             last_feed;

  // Abort only matters while a frame is in progress; in IDLE it is ignored.
  assign abort_active = abort && (state != ST_IDLE);

  // A tail tag is counted only once its column's averaging window is full.
  assign sample_en = tail_valid && (tail_col >= COL_W'(WARMUP));

  // The last column's tag reaching the tail marks the end of the frame.
  // n_q is at least 1 whenever tags are in flight.
  assign last_sample = tail_valid && (tail_col == (n_q - COL_W'(1)));
  assign last_feed   = (feed_col == (n_q - COL_W'(1)));

  // Each fed column launches a tag; it reaches the tail in the same cycle the
  // pipeline presents that column's result.
  valid_tag_delay #(
    .DEPTH (PIPE_LATENCY),
    .W     (COL_W)
  ) u_tags (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (abort_active),
    .in_valid  (feed_en),
    .in_col    (feed_col),
    .out_valid (tail_valid),
    .out_col   (tail_col)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state            <= ST_IDLE;
      n_q              <= '0;
      busy             <= 1'b0;
      feed_en          <= 1'b0;
      feed_col         <= '0;
      report_valid     <= 1'b0;
      report_hit       <= 1'b0;
      report_mask      <= '0;
      report_first_col <= '0;
    end else if (abort_active) begin
      state            <= ST_IDLE;
      n_q              <= '0;
      busy             <= 1'b0;
      feed_en          <= 1'b0;
      feed_col         <= '0;
      report_valid     <= 1'b0;
      report_hit       <= 1'b0;
      report_mask      <= '0;
      report_first_col <= '0;
    end else begin
      // The report registers double as the accumulators; they only move while
      // counted tags are arriving, so they are frozen throughout REPORT.
      if (sample_en) begin
        report_mask <= report_mask | result_in;
        if ((result_in != '0) && !report_hit) begin
          report_hit       <= 1'b1;
          report_first_col <= tail_col;
        end
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            n_q              <= column_count;
            busy             <= 1'b1;
            report_hit       <= 1'b0;
            report_mask      <= '0;
            report_first_col <= '0;
            if (column_count == '0) begin
              state        <= ST_REPORT;
              report_valid <= 1'b1;
            end else begin
              state    <= ST_FEED;
              feed_en  <= 1'b1;
              feed_col <= '0;
            end
          end
        end

        ST_FEED: begin
          if (last_feed) begin
            state    <= ST_DRAIN;
            feed_en  <= 1'b0;
            feed_col <= '0;
          end else begin
            feed_col <= feed_col + COL_W'(1);
          end
        end

        ST_DRAIN: begin
          // The final sample is folded in on this same edge, so the report
          // is complete when report_valid rises.
          if (last_sample) begin
            state        <= ST_REPORT;
            report_valid <= 1'b1;
          end
        end

        ST_REPORT: begin
          if (report_ready) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            report_valid <= 1'b0;
          end
        end

        default: begin
          state        <= ST_IDLE;
          busy         <= 1'b0;
          feed_en      <= 1'b0;
          report_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_edge_frame_sequencer.sv
// tb/tb_edge_frame_sequencer.sv - self-checking bench for edge_frame_sequencer
module tb_edge_frame_sequencer;

  localparam int PH = 5;
  localparam int L  = 13;
  localparam int WU = 7;
  localparam int CW = 8;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          start;
  logic          abort;
  logic [CW-1:0] column_count;
  logic          busy;
  logic          feed_en;
  logic [CW-1:0] feed_col;
  logic [PH-1:0] result_in;
  logic          report_valid;
  logic          report_ready;
  logic          report_hit;
  logic [PH-1:0] report_mask;
  logic [CW-1:0] report_first_col;

  int passed = 0;
  int total  = 0;

  // Per-column result the pipeline presents in that column's sample cycle.
  logic [PH-1:0] res [256];
  bit            junk;

  int            obs_feed, obs_first_feed, obs_last_feed, obs_col_bad, obs_rv_cycle;
  logic          obs_hit;
  logic [PH-1:0] obs_mask;
  logic [CW-1:0] obs_first;

  logic          exp_hit;
  logic [PH-1:0] exp_mask;
  logic [CW-1:0] exp_first;
  int            exp_rv;

  int            fr_bad;
  logic          fr_busy, fr_rv, fr_busy2;

  always #5 clock = ~clock;

  edge_frame_sequencer dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .start            (start),
    .abort            (abort),
    .column_count     (column_count),
    .busy             (busy),
    .feed_en          (feed_en),
    .feed_col         (feed_col),
    .result_in        (result_in),
    .report_valid     (report_valid),
    .report_ready     (report_ready),
    .report_hit       (report_hit),
    .report_mask      (report_mask),
    .report_first_col (report_first_col)
  );

  task automatic clear_res();
    for (int i = 0; i < 256; i++) res[i] = '0;
  endtask

  // Reference: OR over counted columns, earliest counted nonzero column,
  // report one cycle after the last column's sample cycle (cycle 1 for n=0).
  task automatic model(input int n);
    exp_hit = 1'b0; exp_mask = '0; exp_first = '0;
    for (int k = WU; k < n; k++) begin
      if (res[k] != 0 && !exp_hit) begin
        exp_hit = 1'b1;
        exp_first = CW'(k);
      end
      exp_mask = exp_mask | res[k];
    end
    exp_rv = (n == 0) ? 1 : n + L + 1;
  endtask

  // Called at a negedge; starts a frame and returns at the negedge of the
  // cycle where report_valid is first seen (cycles counted from the start edge).
  task automatic drive_frame(input int n);
    int k;
    obs_feed = 0; obs_first_feed = -1; obs_last_feed = -1; obs_col_bad = 0; obs_rv_cycle = -1;
    start = 1'b1;
    column_count = CW'(n);
    @(posedge clock);
    for (int c = 1; c <= 200; c++) begin
      @(negedge clock);
      start = 1'b0;
      column_count = CW'($urandom);
      if (feed_en) begin
        if (obs_first_feed < 0) obs_first_feed = c;
        obs_last_feed = c;
        if (feed_col !== CW'(obs_feed)) obs_col_bad++;
        obs_feed++;
      end
      k = c - 1 - L;
      if (k >= 0 && k < n) result_in = res[k];
      else if (junk) result_in = PH'($urandom);
      else result_in = '0;
      if (report_valid) begin
        obs_rv_cycle = c;
        obs_hit = report_hit;
        obs_mask = report_mask;
        obs_first = report_first_col;
        break;
      end
    end
  endtask

  // Holds ready low for delay cycles (optionally poking start), then completes
  // the handshake; start is also raised on the handshake edge when poke is set.
  task automatic finish_report(input int delay, input bit poke);
    fr_bad = 0;
    for (int i = 0; i < delay; i++) begin
      start = poke && (i == delay / 2);
      column_count = CW'(5);
      @(negedge clock);
      start = 1'b0;
      if (report_valid !== 1'b1 || busy !== 1'b1 || feed_en !== 1'b0 ||
          report_hit !== exp_hit || report_mask !== exp_mask || report_first_col !== exp_first)
        fr_bad++;
    end
    start = poke;
    report_ready = 1'b1;
    @(negedge clock);
    report_ready = 1'b0;
    start = 1'b0;
    fr_busy = busy;
    fr_rv = report_valid;
    @(negedge clock);
    fr_busy2 = busy | feed_en;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; report_ready = 1'b0;
    column_count = '0; result_in = '0; junk = 1'b0;
    repeat (3) @(negedge clock);
    total++;
    if ({busy, feed_en, feed_col, report_valid, report_hit, report_mask, report_first_col} !== '0)
      $display("FAIL reset_outputs: got busy=%b feed_en=%b feed_col=%0d rv=%b hit=%b mask=%b first=%0d, want all 0",
               busy, feed_en, feed_col, report_valid, report_hit, report_mask, report_first_col);
    else passed++;
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_blank_frame();
    clear_res(); junk = 1'b0; model(20);
    drive_frame(20);
    total++;
    if (obs_feed !== 20 || obs_first_feed !== 1 || obs_last_feed !== 20)
      $display("FAIL blank_feed_window: got count=%0d first=%0d last=%0d, want 20/1/20", obs_feed, obs_first_feed, obs_last_feed);
    else passed++;
    total++;
    if (obs_col_bad !== 0) $display("FAIL blank_feed_col: got %0d bad indices, want 0", obs_col_bad);
    else passed++;
    total++;
    if (obs_rv_cycle !== 34) $display("FAIL blank_rv_cycle: got %0d want 34", obs_rv_cycle);
    else passed++;
    total++;
    if ({obs_hit, obs_mask, obs_first} !== {exp_hit, exp_mask, exp_first})
      $display("FAIL blank_report: got hit=%b mask=%b first=%0d, want 0/0/0", obs_hit, obs_mask, obs_first);
    else passed++;
    finish_report(0, 1'b0);
    total++;
    if (fr_busy !== 1'b0 || fr_rv !== 1'b0) $display("FAIL blank_handshake: got busy=%b rv=%b, want 0/0", fr_busy, fr_rv);
    else passed++;
  endtask

  task automatic test_detect_hits();
    clear_res(); res[9] = 5'b00100; res[15] = 5'b10000; junk = 1'b1; model(20);
    drive_frame(20);
    total++;
    if (obs_rv_cycle !== 34) $display("FAIL hits_rv_cycle: got %0d want 34", obs_rv_cycle);
    else passed++;
    total++;
    if (obs_hit !== 1'b1 || obs_mask !== 5'b10100 || obs_first !== 8'd9)
      $display("FAIL hits_report: got hit=%b mask=%b first=%0d, want 1/10100/9", obs_hit, obs_mask, obs_first);
    else passed++;
    finish_report(0, 1'b0);
  endtask

  task automatic test_warmup_suppress();
    clear_res(); junk = 1'b0;
    for (int k = 0; k < WU; k++) res[k] = 5'b11111;
    model(20);
    drive_frame(20);
    total++;
    if (obs_hit !== 1'b0 || obs_mask !== 5'b00000 || obs_first !== 8'd0)
      $display("FAIL warmup_report: got hit=%b mask=%b first=%0d, want 0/0/0", obs_hit, obs_mask, obs_first);
    else passed++;
    finish_report(0, 1'b0);
  endtask

  task automatic test_report_hold();
    clear_res(); res[12] = 5'b01001; res[19] = 5'b00110; junk = 1'b1; model(20);
    drive_frame(20);
    total++;
    if (obs_rv_cycle !== exp_rv) $display("FAIL hold_rv_cycle: got %0d want %0d", obs_rv_cycle, exp_rv);
    else passed++;
    finish_report(10, 1'b1);
    total++;
    if (fr_bad !== 0) $display("FAIL hold_stable: got %0d unstable cycles, want 0", fr_bad);
    else passed++;
    total++;
    if (fr_busy !== 1'b0 || fr_rv !== 1'b0) $display("FAIL hold_release: got busy=%b rv=%b, want 0/0", fr_busy, fr_rv);
    else passed++;
    total++;
    if (fr_busy2 !== 1'b0) $display("FAIL hold_start_ignored: got busy|feed_en=%b want 0", fr_busy2);
    else passed++;
  endtask

  task automatic test_zero_and_abort();
    logic seen;
    clear_res(); junk = 1'b1; model(0);
    drive_frame(0);
    total++;
    if (obs_rv_cycle !== 1 || obs_feed !== 0 || obs_hit !== 1'b0 || obs_mask !== '0)
      $display("FAIL zero_frame: got rv_cycle=%0d feeds=%0d hit=%b mask=%b, want 1/0/0/0", obs_rv_cycle, obs_feed, obs_hit, obs_mask);
    else passed++;
    finish_report(1, 1'b0);

    start = 1'b1; column_count = 8'd20;
    @(posedge clock);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clock);
      start = 1'b0;
      result_in = PH'($urandom);
    end
    total++;
    if (feed_en !== 1'b1 || feed_col !== 8'd5) $display("FAIL abort5_position: got feed_en=%b feed_col=%0d, want 1/5", feed_en, feed_col);
    else passed++;
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    total++;
    if ({busy, feed_en, report_valid} !== 3'b000) $display("FAIL abort5_idle: got busy=%b feed_en=%b rv=%b, want 000", busy, feed_en, report_valid);
    else passed++;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      result_in = PH'($urandom);
      seen = seen | report_valid | busy | feed_en;
    end
    total++;
    if (seen !== 1'b0) $display("FAIL abort5_quiet: got activity=%b after abort, want 0", seen);
    else passed++;

    // Abort with counted columns in flight, then restart at once: stale tags
    // would fold junk into the new frame's report.
    start = 1'b1; column_count = 8'd20;
    @(posedge clock);
    for (int c = 1; c <= 13; c++) begin
      @(negedge clock);
      start = 1'b0;
      result_in = PH'($urandom);
    end
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    clear_res(); junk = 1'b1; model(20);
    drive_frame(20);
    total++;
    if (obs_rv_cycle !== 34 || obs_hit !== 1'b0 || obs_mask !== '0 || obs_first !== '0)
      $display("FAIL abort_flush: got rv_cycle=%0d hit=%b mask=%b first=%0d, want 34/0/0/0", obs_rv_cycle, obs_hit, obs_mask, obs_first);
    else passed++;
    finish_report(0, 1'b0);
  endtask

  task automatic test_reset_mid_drain();
    int k;
    clear_res(); res[8] = 5'b00011;
    start = 1'b1; column_count = 8'd20;
    @(posedge clock);
    for (int c = 1; c <= 25; c++) begin
      @(negedge clock);
      start = 1'b0;
      k = c - 1 - L;
      result_in = (k >= 0 && k < 20) ? res[k] : '0;
    end
    total++;
    if (busy !== 1'b1 || feed_en !== 1'b0 || report_hit !== 1'b1)
      $display("FAIL drain_state: got busy=%b feed_en=%b hit=%b, want 1/0/1", busy, feed_en, report_hit);
    else passed++;
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({busy, feed_en, feed_col, report_valid, report_hit, report_mask, report_first_col} !== '0)
      $display("FAIL async_reset: got busy=%b feed_en=%b rv=%b hit=%b mask=%b first=%0d, want all 0",
               busy, feed_en, report_valid, report_hit, report_mask, report_first_col);
    else passed++;
    @(negedge clock);
    reset_n = 1'b1;
    clear_res(); junk = 1'b0; model(10);
    drive_frame(10);
    total++;
    if (obs_rv_cycle !== 24 || obs_feed !== 10 || obs_hit !== 1'b0)
      $display("FAIL after_reset_frame: got rv_cycle=%0d feeds=%0d hit=%b, want 24/10/0", obs_rv_cycle, obs_feed, obs_hit);
    else passed++;
    finish_report(0, 1'b0);
  endtask

  task automatic test_random_frames();
    int n;
    for (int f = 0; f < 10; f++) begin
      n = $urandom_range(0, 30);
      clear_res();
      for (int k = 0; k < n; k++) if ($urandom_range(0, 3) == 0) res[k] = PH'($urandom);
      junk = 1'b1;
      model(n);
      drive_frame(n);
      total++;
      if (obs_rv_cycle !== exp_rv || obs_feed !== n || obs_col_bad !== 0)
        $display("FAIL rand_timing f=%0d n=%0d: got rv_cycle=%0d feeds=%0d badcol=%0d, want %0d/%0d/0",
                 f, n, obs_rv_cycle, obs_feed, obs_col_bad, exp_rv, n);
      else passed++;
      total++;
      if ({obs_hit, obs_mask, obs_first} !== {exp_hit, exp_mask, exp_first})
        $display("FAIL rand_report f=%0d n=%0d: got hit=%b mask=%b first=%0d, want %b/%b/%0d",
                 f, n, obs_hit, obs_mask, obs_first, exp_hit, exp_mask, exp_first);
      else passed++;
      finish_report($urandom_range(0, 3), 1'(($urandom_range(0, 1))));
      total++;
      if (fr_bad !== 0 || fr_busy !== 1'b0 || fr_busy2 !== 1'b0)
        $display("FAIL rand_handshake f=%0d: got unstable=%0d busy=%b after=%b, want 0/0/0", f, fr_bad, fr_busy, fr_busy2);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_blank_frame();
    test_detect_hits();
    test_warmup_suppress();
    test_report_hold();
    test_zero_and_abort();
    test_reset_mid_drain();
    test_random_frames();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
